gshare_branch_predictor: RTL
============================

# gshare_branch_predictor

Fetch-stage next-PC predictor: a direct-mapped BTB plus a gshare pattern-history table of 2-bit saturating counters, indexed by PC XOR global history. It sits upstream of the IF/ID pipeline register and drives the PC's `next_pc` input. It accepts resolution updates from the EX stage and flags mispredictions so the pipeline can flush IF/ID and ID/EX.

## Interface
- `ENTRIES`, 32, BTB and PHT depth; power of two, ≥ 4; `IDX_BITS = log2(ENTRIES)`.
- `GHR_BITS`, 5, global history length; 1 ≤ `GHR_BITS` ≤ `IDX_BITS`.
- `clk`  in  1  clock; one clock domain; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `pc`  in  32  PC of the instruction currently being fetched.
- `pred_next_pc`  out  32  predicted next PC.
- `pred_taken`  out  1  prediction is taken (BTB target used).
- `pred_index`  out  `IDX_BITS`  PHT index used for this prediction; travels down IF/ID and ID/EX.
- `upd_valid`  in  1  EX resolves a branch/JAL/JALR this cycle.
- `upd_pc`  in  32  PC of the resolving instruction.
- `upd_index`  in  `IDX_BITS`  `pred_index` carried with that instruction.
- `upd_taken`  in  1  actual direction (1 for JAL/JALR).
- `upd_target`  in  32  actual taken target.
- `upd_pred_taken`  in  1  `pred_taken` carried with the instruction.
- `upd_pred_target`  in  32  `pred_next_pc` carried with the instruction.
- `mispredict`  out  1  flush request.
- `correct_pc`  out  32  redirect PC; valid when `mispredict` = 1.

## Operation
- Fields:
  - `bidx = pc[IDX_BITS+1:2]`.
  - `tag = pc[31:IDX_BITS+2]`.
  - `pidx = bidx ^ {{(IDX_BITS-GHR_BITS){0}}, ghr}`.
- State:
  - BTB entry = {`valid`, `tag`, `target[31:0]`}.
  - PHT = `ENTRIES` × 2-bit counters: SNT = 0, WNT = 1, WT = 2, ST = 3.
  - `ghr` holds `GHR_BITS` bits.
- Predict (combinational):
  - `hit = btb[bidx].valid & (btb[bidx].tag == tag)`.
  - `pred_taken = hit & pht[pidx][1]`.
  - `pred_next_pc = pred_taken ? btb[bidx].target : pc + 4`.
  - `pred_index = pidx`.
- Update (at edge, when `upd_valid`):
  - PHT: `pht[upd_index]` increments if taken, decrements otherwise, saturating at 3/0.
  - BTB: if taken, write `btb[upd_pc[IDX_BITS+1:2]] <= {1, upd_pc tag, upd_target}`. Not-taken never invalidates.
  - GHR: `ghr <= {ghr[GHR_BITS-2:0], upd_taken}`; for `GHR_BITS` = 1, `ghr <= upd_taken`.
  - The PHT index comes only from `upd_index`; it is never recomputed from the current `ghr`.
- Mispredict (combinational):
  - `mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & (upd_target != upd_pred_target)))`.
  - `correct_pc = upd_taken ? upd_target : upd_pc + 4`.
- History is non-speculative: flushed instructions never touch `ghr`, and the EX stage asserts `upd_valid` only for unflushed control-flow instructions.
- PC arithmetic is modulo 2^32: `pc + 4` at `0xFFFF_FFFC` wraps to 0.

## Timing
- Prediction latency 0 cycles; `mispredict`/`correct_pc` latency 0 cycles.
- Update is visible to predictions from the next cycle.
- Same-cycle read and write of the same entry: the prediction uses the pre-edge value.
- Reset values:
  - All BTB `valid` = 0, all PHT = WNT, `ghr` = 0.
  - `pred_taken` = 0, `pred_next_pc` = `pc + 4`, `mispredict` = 0 when `upd_valid` = 0.
- `reset` asserted together with `upd_valid`: reset wins and the update is dropped.
- No stall input: holding `pc` constant repeats the same prediction; state is unchanged without `upd_valid`.

## Structure
- Shared package `bp_pkg`: counter encodings SNT/WNT/WT/ST, `ENTRIES`/`GHR_BITS` defaults, BTB entry struct typedef.
- One sub-module, `sat_counter_table`: `ENTRIES` × 2-bit counters, one async read port, one saturating inc/dec write port, reset to WNT.

## Test plan
- **Reset default:** reset, then `pc = 0x10` -> `pred_next_pc = 0x14`, `pred_taken = 0`, `pred_index = 4`, `mispredict = 0`.
- **Taken update:** `upd_valid`, `upd_pc = 0x10`, `upd_index = 4`, `upd_taken = 1`, `upd_target = 0x40`, `upd_pred_taken = 0`, `upd_pred_target = 0x14`.
  - Same cycle: `mispredict = 1`, `correct_pc = 0x40`.
  - Next cycle: `ghr = 1`, `pht[4] = WT`; `pc = 0x10` -> `pred_index = 5`, `pred_taken = 0`, `pred_next_pc = 0x14`.
- **Saturation:** from reset, five taken updates to `upd_index = 9` -> `pht[9] = ST`. One not-taken update -> `pht[9] = WT` and `ghr = 0b11110`. With BTB hit and `pidx = 9`, `pred_taken` = 1.
- **Not-taken mispredict:** `upd_taken = 0`, `upd_pred_taken = 1`, `upd_pred_target = 0x40`, `upd_pc = 0x10` -> `mispredict = 1`, `correct_pc = 0x14`; BTB entry 4 stays valid.
- **Tag mismatch:** BTB[4] holds `pc 0x10` and counters are taken; `pc = 0x90` (same `bidx`, different tag) -> `pred_taken = 0`, `pred_next_pc = 0x94`.
- **Reset priority:** `reset = 1` and `upd_valid = 1` on the same edge -> next cycle all BTB invalid, PHT = WNT, `ghr = 0`.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and defaults for the gshare branch predictor: counter encodings
// and the BTB entry layout.
package bp_pkg;

  localparam int unsigned ENTRIES_DEFAULT  = 32;
  localparam int unsigned GHR_BITS_DEFAULT = 5;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  // tag holds pc >> (IDX_BITS+2) zero-extended, so the layout is independent of ENTRIES
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter_table.sv
// Table of 2-bit saturating counters with one asynchronous read port and one
// increment/decrement write port; counters reset to weakly-not-taken.
module sat_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = ENTRIES_DEFAULT,
  localparam int unsigned IDX_BITS = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_index,
  output ctr_e                rd_value,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_index,
  input  logic                wr_inc
);

  ctr_e cnt [ENTRIES];
  ctr_e wr_cur;
  ctr_e wr_nxt;

  assign rd_value = cnt[rd_index];

  always_comb begin
    wr_cur = cnt[wr_index];
    wr_nxt = wr_cur;
    if (wr_inc) begin
      wr_nxt = (wr_cur == ST) ? ST : ctr_e'(wr_cur + 2'd1);
    end else begin
      wr_nxt = (wr_cur == SNT) ? SNT : ctr_e'(wr_cur - 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        cnt[i] <= WNT;
      end
    end else if (wr_en) begin
      cnt[wr_index] <= wr_nxt;
    end
  end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Fetch-stage next-PC predictor: direct-mapped BTB plus gshare PHT, with
// non-speculative history updated from EX resolutions and a mispredict flag.
module gshare_branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES  = ENTRIES_DEFAULT,
  parameter int unsigned GHR_BITS = GHR_BITS_DEFAULT,
  localparam int unsigned IDX_BITS = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         pc,
  output logic [31:0]         pred_next_pc,
  output logic                pred_taken,
  output logic [IDX_BITS-1:0] pred_index,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic [IDX_BITS-1:0] upd_index,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic                upd_pred_taken,
  input  logic [31:0]         upd_pred_target,
  output logic                mispredict,
  output logic [31:0]         correct_pc
);

  logic [IDX_BITS-1:0] bidx;
  logic [IDX_BITS-1:0] pidx;
  logic [IDX_BITS-1:0] upd_bidx;
  logic [29:0]         tag;
  logic [29:0]         upd_tag;
  logic [GHR_BITS-1:0] ghr;
  logic [GHR_BITS-1:0] ghr_next;
  btb_entry_t          btb [ENTRIES];
  btb_entry_t          rd_entry;
  ctr_e                pht_value;
  logic                hit;

  assign bidx     = pc[IDX_BITS+1:2];
  assign upd_bidx = upd_pc[IDX_BITS+1:2];
  assign tag      = 30'(pc >> (IDX_BITS + 2));
  assign upd_tag  = 30'(upd_pc >> (IDX_BITS + 2));
  assign pidx     = bidx ^ IDX_BITS'(ghr);

  if (GHR_BITS == 1) begin : g_ghr_single
    assign ghr_next = upd_taken;
  end else begin : g_ghr_shift
    assign ghr_next = {ghr[GHR_BITS-2:0], upd_taken};
  end

  sat_counter_table #(
    .ENTRIES (ENTRIES)
  ) u_pht (
    .clk      (clk),
    .reset    (reset),
    .rd_index (pidx),
    .rd_value (pht_value),
    .wr_en    (upd_valid),
    .wr_index (upd_index),
    .wr_inc   (upd_taken)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        btb[i] <= '0;
      end
    end else if (upd_valid) begin
      ghr <= ghr_next;
      // Not-taken resolutions leave the BTB alone so a loop exit keeps its target.
      if (upd_taken) begin
        btb[upd_bidx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target};
      end
    end
  end

  always_comb begin
    rd_entry     = btb[bidx];
    hit          = rd_entry.valid && (rd_entry.tag == tag);
    pred_taken   = hit && pht_value[1];
    pred_next_pc = pred_taken ? rd_entry.target : pc + 32'd4;
    pred_index   = pidx;
  end

  always_comb begin
    mispredict = upd_valid && ((upd_taken != upd_pred_taken) ||
                               (upd_taken && (upd_target != upd_pred_target)));
    correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;
  end

endmodule
